cubehash_exp_core: RTL and testbench
====================================

Name: cubehash_exp_core

Overview:
- Byte-serial CubeHash r/b-h hash engine; default CubeHash16/32-256.
- A host supplies pre-padded 32-byte message blocks one byte at a time, framed by a start level.
- The core iterates one CubeHash round per clock and streams the digest out one byte per cycle.
- It sits behind a slow byte-wide host interface.

Parameters:
- ROUNDS, 16: rounds per block (r).
- BLOCK_BYTES, 32: bytes per absorbed block (b). Fixed at 32.
- HASH_BYTES, 32: digest length in bytes (h/8).

Ports:
- clk  in  1  rising-edge clock.
- rst_p  in  1  asynchronous active-high reset.
- in_en  in  1  interface enable; when low, start edges and load pulses are ignored.
- part_msg  in  8  message byte, sampled on the load rising edge.
- load  in  1  byte strobe; each 0->1 transition (clk-synchronous edge detect) captures one byte; width arbitrary.
- start  in  1  message frame; rising edge begins a hash, falling edge requests finalization.
- out_en  out  1  high while hash1 carries a valid digest byte.
- hash1  out  8  digest byte stream.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: state, byte buffer and counters cleared; FSM=IDLE; out_en=0, hash1=0, err=0.
- State: 32 x 32-bit words x[0..31].
- Round, one per clock; all additions mod 2^32, j over 0..15 unless noted:
  - x[j+16] += x[j]
  - x[j] rotl 7
  - swap x[j] with x[j^8] for j<8
  - x[j] ^= x[j+16]
  - swap x[j+16] with x[j^2+16] for j in {16+0,1,4,5,8,9,12,13}-16
  - x[j+16] += x[j]
  - x[j] rotl 11
  - swap x[j] with x[j^4] for j in {0,1,2,3,8,9,10,11}
  - x[j] ^= x[j+16]
  - swap x[j+16] with x[j^1+16] for even j
- FSM states: IDLE, INIT, WAIT, ABSORB, FINAL, OUTPUT.
- IDLE:
  - start rising edge with in_en=1 -> INIT.
  - Load x0=HASH_BYTES, x1=BLOCK_BYTES, x2=ROUNDS, rest 0; clear err and the byte counter.
- INIT: 10*ROUNDS rounds (160 cycles) -> WAIT.
- Byte capture:
  - Operates from INIT onward, independent of rounds; only while start=1 and in_en=1.
  - Byte k (0..31) is written to buffer byte k.
  - Buffer byte k maps to word k/4, bits 8*(k%4)+7:8*(k%4) (little-endian).
  - After byte 31 the buffer is marked full and the counter wraps to 0.
- WAIT:
  - Buffer full -> XOR buffer into x[0..7], clear full, go ABSORB.
  - start falls, buffer not full, counter=0 -> x[31] ^= 1, go FINAL.
- ABSORB: ROUNDS rounds -> WAIT.
- FINAL: 10*ROUNDS rounds -> OUTPUT.
- Early start fall: a start fall during INIT/ABSORB is latched and serviced in WAIT after any pending full block is absorbed.
- OUTPUT:
  - out_en=1 for exactly HASH_BYTES consecutive cycles.
  - hash1 = digest byte i on cycle i: byte i = bits 8*(i%4)+7:8*(i%4) of x[i/4]; byte 0 first.
  - Then out_en=0, hash1 held at 0, -> IDLE.
- err set, and held until reset or the next accepted start rise, on:
  - a load edge while the buffer is still full (the byte is dropped);
  - start falling with a partial block (counter != 0), which also aborts to IDLE with no output;
  - a load edge while start=0 (the byte is ignored).
- Mid-operation events:
  - start rising edge outside IDLE: ignored.
  - in_en low mid-hash: freezes capture only; rounds continue.
  - Reset mid-operation: immediate return to reset state.

Test Plan:
- Empty message, default params:
  - Stimulus: start, load 0x80 then 31 x 0x00 with 10-cycle load pulses, drop start.
  - Response: out_en high 32 cycles; hash1 = 44 c6 de 3a ... (CubeHash160+16/32+160-256 of "", full value 44c6de3ac6c73c391bf0906cb7482600ec06b216c7c54a2a8688a6a42676577d).
- Latency: from the cycle start falls in WAIT to the first out_en = 1 + 160 cycles ±1. Check exactly 32 out_en cycles, then out_en=0 and hash1=0.
- Two-block message:
  - Stimulus: 64 bytes (e.g. bytes 00..00 with 0x80 at byte 3 of block 1, zeros after).
  - Response: digest matches the software model; err=0.
- Partial block: start falls after 5 bytes -> err=1, no out_en pulse. Next start rise clears err.
- Overrun and ignored loads:
  - Feed 32 bytes during INIT, then immediately feed a 33rd byte before absorption -> err=1.
  - A load pulse with start=0 -> err=1, no state change.
- Async reset asserted during FINAL -> out_en=0, hash1=0, err=0 within the same cycle; a new hash afterwards produces the correct digest.

Source files
------------

// File: rtl/cubehash_exp_core_if.sv
// cubehash_exp_core_if: byte-wide host bus of the CubeHash engine
interface cubehash_exp_core_if;
    logic       in_en;
    logic [7:0] part_msg;
    logic       load;
    logic       start;
    logic       out_en;
    logic [7:0] hash1;
    logic       err;
    modport master(output in_en, part_msg, load, start, input out_en, hash1, err);
    modport slave(input in_en, part_msg, load, start, output out_en, hash1, err);
endinterface

// File: rtl/cubehash_exp_core.sv
// cubehash_exp_core: byte-serial CubeHash r/b-h engine, one round per clock, byte-wide digest stream
module cubehash_exp_core #(
    parameter int ROUNDS = 16,
    parameter int BLOCK_BYTES = 32,
    parameter int HASH_BYTES = 32
) (
    input logic clk,
    input logic rst_p,
    cubehash_exp_core_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, WAIT, ABSORB, FINAL, OUTPUT} state_t;
    localparam logic [15:0] LONG_LAST = 16'(10 * ROUNDS - 1);
    localparam logic [15:0] ABS_LAST = 16'(ROUNDS - 1);
    localparam logic [15:0] OUT_LAST = 16'(HASH_BYTES - 1);
    state_t state, state_d;
    logic [31:0][31:0] x, x_rnd;
    logic [31:0][7:0] blk;
    logic [15:0][31:0] hi1, lo1, lo2, hi2, hi3, lo3, lo4, hi4;
    logic [4:0] cnt;
    logic [15:0] rnd;
    logic full, fin_req, err, start_q, load_q;
    logic start_rise, start_fall, load_rise, go, cap, fin_ev;
    for (genvar i = 0; i < 16; i++) begin : g_round
        assign hi1[i] = x[i + 16] + x[i];
        assign lo1[i] = {x[i][24:0], x[i][31:25]};
        assign lo2[i] = lo1[i ^ 8] ^ hi1[i];
        assign hi2[i] = hi1[i ^ 2];
        assign hi3[i] = hi2[i] + lo2[i];
        assign lo3[i] = {lo2[i][20:0], lo2[i][31:21]};
        assign lo4[i] = lo3[i ^ 4] ^ hi3[i];
        assign hi4[i] = hi3[i ^ 1];
    end
    assign x_rnd = {hi4, lo4};
    assign start_rise = bus.in_en & bus.start & ~start_q;
    assign start_fall = bus.in_en & ~bus.start & start_q;
    assign load_rise = bus.in_en & bus.load & ~load_q;
    assign go = (state == IDLE) & start_rise;
    assign cap = (state != IDLE) & bus.start & load_rise;
    assign fin_ev = fin_req | start_fall;
    assign bus.out_en = state == OUTPUT;
    assign bus.hash1 = (state == OUTPUT) ? x[0][7:0] : '0;
    assign bus.err = err;
    always_ff @(posedge clk or posedge rst_p)
        if (rst_p) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = go ? INIT : IDLE;
            INIT:    state_d = (rnd == LONG_LAST) ? WAIT : INIT;
            WAIT:    state_d = full ? ABSORB : !fin_ev ? WAIT : (cnt == '0) ? FINAL : IDLE;
            ABSORB:  state_d = (rnd == ABS_LAST) ? WAIT : ABSORB;
            FINAL:   state_d = (rnd == LONG_LAST) ? OUTPUT : FINAL;
            OUTPUT:  state_d = (rnd == OUT_LAST) ? IDLE : OUTPUT;
            default: state_d = IDLE;
        endcase
    end
    // digest leaves through x[0][7:0] while the state shifts down a byte per cycle
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            x <= '0;
            blk <= '0;
            cnt <= '0;
            rnd <= '0;
            full <= 1'b0;
            fin_req <= 1'b0;
            err <= 1'b0;
            start_q <= 1'b0;
            load_q <= 1'b0;
        end else begin
            start_q <= bus.start;
            load_q <= bus.load;
            rnd <= (state_d == state) ? rnd + 16'd1 : '0;
            case (state)
                IDLE:    if (go) x <= {928'b0, 32'(ROUNDS), 32'(BLOCK_BYTES), 32'(HASH_BYTES)};
                WAIT:    if (full) x[7:0] <= x[7:0] ^ blk;
                         else if (fin_ev && cnt == '0) x[31][0] <= ~x[31][0];
                OUTPUT:  x <= x >> 8;
                default: x <= x_rnd;
            endcase
            if (go) begin
                cnt <= '0;
                full <= 1'b0;
                fin_req <= 1'b0;
                err <= 1'b0;
            end else begin
                if (cap && full) err <= 1'b1;
                if (cap && !full) begin
                    blk[cnt] <= bus.part_msg;
                    cnt <= cnt + 5'd1;
                    full <= cnt == 5'd31;
                end
                if (state == WAIT && full) full <= 1'b0;
                if (load_rise && !bus.start) err <= 1'b1;
                if ((state == INIT || state == ABSORB || state == WAIT) && start_fall) fin_req <= 1'b1;
                if (state == WAIT && !full && fin_ev) begin
                    fin_req <= 1'b0;
                    if (cnt != '0) err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cubehash_exp_core.sv
// tb_cubehash_exp_core: directed bench with a software CubeHash16/32-256 model and a per-cycle output checker
module tb_cubehash_exp_core;
    logic clk = 1'b0;
    logic rst_p = 1'b1;
    int errors = 0;
    int checks = 0;
    int oidx = 0;
    int unsigned s[32];
    byte unsigned msg[$];
    byte unsigned exp_dig[32];
    logic [255:0] ref_dig = 256'h44c6de3ac6c73c391bf0906cb7482600ec06b216c7c54a2a8688a6a42676577d;

    cubehash_exp_core_if bus();
    cubehash_exp_core #(.ROUNDS(16), .BLOCK_BYTES(32), .HASH_BYTES(32)) dut (
        .clk(clk), .rst_p(rst_p), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_round();
        int unsigned t;
        for (int j = 0; j < 16; j++) s[j + 16] += s[j];
        for (int j = 0; j < 16; j++) s[j] = (s[j] << 7) | (s[j] >> 25);
        for (int j = 0; j < 8; j++) begin t = s[j]; s[j] = s[j + 8]; s[j + 8] = t; end
        for (int j = 0; j < 16; j++) s[j] ^= s[j + 16];
        for (int j = 0; j < 16; j++)
            if ((j & 2) == 0) begin t = s[j + 16]; s[j + 16] = s[j + 18]; s[j + 18] = t; end
        for (int j = 0; j < 16; j++) s[j + 16] += s[j];
        for (int j = 0; j < 16; j++) s[j] = (s[j] << 11) | (s[j] >> 21);
        for (int j = 0; j < 16; j++)
            if ((j & 4) == 0) begin t = s[j]; s[j] = s[j + 4]; s[j + 4] = t; end
        for (int j = 0; j < 16; j++) s[j] ^= s[j + 16];
        for (int j = 0; j < 16; j += 2) begin t = s[j + 16]; s[j + 16] = s[j + 17]; s[j + 17] = t; end
    endtask

    // whole 32-byte blocks of msg are absorbed; any trailing byte was dropped by the core
    task automatic model();
        int nb;
        nb = msg.size() / 32;
        for (int i = 0; i < 32; i++) s[i] = 0;
        s[0] = 32; s[1] = 32; s[2] = 16;
        repeat (160) model_round();
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 32; k++) s[k / 4] ^= 32'(msg[b * 32 + k]) << (8 * (k % 4));
            repeat (16) model_round();
        end
        s[31] ^= 1;
        repeat (160) model_round();
        for (int i = 0; i < 32; i++) exp_dig[i] = 8'(s[i / 4] >> (8 * (i % 4)));
    endtask

    task automatic send(input byte unsigned b, input int hw, input int lw);
        bus.part_msg = b;
        bus.load = 1'b1;
        repeat (hw) tick();
        bus.load = 1'b0;
        repeat (lw) tick();
    endtask

    task automatic run_hash(input int hw, input int lw, input int settle, input logic exp_err, input bit meas_lat);
        int n;
        model();
        oidx = 0;
        bus.start = 1'b1;
        tick();
        tick();
        check("err_clear_on_start", bus.err, 1'b0);
        foreach (msg[k]) send(msg[k], hw, lw);
        repeat (settle) tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.out_en && n < 2000) begin tick(); n++; end
        check("out_en_rise", bus.out_en, 1'b1);
        if (meas_lat) begin
            checks++;
            if (n < 160 || n > 162) begin
                errors++;
                $display("FAIL latency: got %0d cycles expected 160..162", n);
            end
        end
        n = 0;
        while (bus.out_en && n < 40) begin tick(); n++; end
        check("out_en_cycles", oidx, 32);
        check("out_en_after", bus.out_en, 1'b0);
        check("hash1_after", bus.hash1, 8'h00);
        check("err_after_hash", bus.err, exp_err);
    endtask

    always @(negedge clk) begin
        if (bus.out_en) begin
            if (oidx < 32) check("hash1_byte", bus.hash1, exp_dig[oidx]);
            oidx++;
        end else check("hash1_idle", bus.hash1, 8'h00);
    end

    initial begin
        bus.in_en = 1'b1;
        bus.part_msg = 8'h00;
        bus.load = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();
        check("rst_out_en", bus.out_en, 1'b0);
        check("rst_hash1", bus.hash1, 8'h00);
        check("rst_err", bus.err, 1'b0);
        rst_p = 1'b0;
        tick();

        // empty message: model pinned to the published digest, then DUT compared
        msg = {};
        msg.push_back(8'h80);
        repeat (31) msg.push_back(8'h00);
        model();
        for (int i = 0; i < 32; i++) check("model_empty_ref", exp_dig[i], ref_dig[255 - 8 * i -: 8]);
        check("model_byte0", exp_dig[0], 8'h44);
        check("model_byte1", exp_dig[1], 8'hc6);
        check("model_byte2", exp_dig[2], 8'hde);
        check("model_byte3", exp_dig[3], 8'h3a);
        run_hash(10, 2, 40, 1'b0, 1'b1);

        // two blocks, start drops right after the last byte
        msg = {};
        repeat (64) msg.push_back(8'h00);
        msg[35] = 8'h80;
        run_hash(3, 3, 0, 1'b0, 1'b0);

        // partial block aborts with err and no output
        oidx = 0;
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send(8'(i + 1), 2, 2);
        bus.start = 1'b0;
        repeat (200) tick();
        check("partial_err", bus.err, 1'b1);
        check("partial_no_out", oidx, 0);

        // zero-block hash, also shows err cleared by the next start
        msg = {};
        run_hash(1, 1, 0, 1'b0, 1'b0);

        // load with start low: err, no activity
        oidx = 0;
        send(8'h55, 2, 20);
        check("load_nostart_err", bus.err, 1'b1);
        check("load_nostart_no_out", oidx, 0);

        // overrun: 33rd byte dropped while the buffer is full
        msg = {};
        for (int i = 0; i < 33; i++) msg.push_back(8'(i * 7 + 1));
        run_hash(1, 1, 40, 1'b1, 1'b0);

        // async reset in FINAL
        bus.start = 1'b1;
        tick();
        foreach (msg[k]) send(msg[k], 1, 1);
        repeat (20) tick();
        bus.start = 1'b0;
        repeat (150) tick();
        check("err_before_rst", bus.err, 1'b1);
        #2 rst_p = 1'b1;
        #1;
        check("rst_mid_out_en", bus.out_en, 1'b0);
        check("rst_mid_hash1", bus.hash1, 8'h00);
        check("rst_mid_err", bus.err, 1'b0);
        tick();
        rst_p = 1'b0;
        tick();
        msg = {};
        msg.push_back(8'h80);
        repeat (31) msg.push_back(8'h00);
        run_hash(10, 2, 40, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
